ram_loader: RTL

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// Boot loader that streams bytes from a source into RAM over the shared CPU bus.
// Define RAM_LOADER_VERIFY_EN to add a readback VERIFY phase and a sticky error flag.
module ram_loader #(
  parameter logic [3:0] LAST_ADDR = 4'hF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  inout  wire  [7:0] bus,
  output logic       mar_load,
  output logic       ram_load,
  output logic       ram_out,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
`ifdef RAM_LOADER_VERIFY_EN
    VERIFY = 3'd4,
`endif
    DONE   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       error_q, error_d;
  logic       bus_oe;
  logic [7:0] bus_val;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      addr_q  <= 4'h0;
      data_q  <= 8'h00;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  // Outputs are pure state decodes, so clr forcing IDLE also silences every strobe.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    error_d  = error_q;
    in_ready = 1'b0;
    mar_load = 1'b0;
    ram_load = 1'b0;
    ram_out  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    bus_oe   = 1'b0;
    bus_val  = 8'h00;
    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          addr_d  = 4'h0;
          error_d = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        busy     = 1'b1;
        bus_oe   = 1'b1;
        bus_val  = {4'h0, addr_q};
        mar_load = 1'b1;
        state_d  = DATA;
      end
      DATA: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy     = 1'b1;
        bus_oe   = 1'b1;
        bus_val  = data_q;
        ram_load = 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
        state_d  = VERIFY;
`else
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 4'h1;
          state_d = ADDR;
        end
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      VERIFY: begin
        busy    = 1'b1;
        ram_out = 1'b1;
        if (bus != data_q) begin
          error_d = 1'b1;
        end
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 4'h1;
          state_d = ADDR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus = bus_oe ? bus_val : 8'hZZ;
  assign error = error_q;

endmodule
